// File: rtl/stack_arbiter_pkg.sv
// Shared constants for the two-requester stack arbiter: stack pointer
// control codes and controller state encodings.
package stack_arbiter_pkg;

    typedef enum logic [1:0] {
        SP_DEF  = 2'd0,
        SP_PUSH = 2'd1,
        SP_POP  = 2'd2
    } sp_ctrl_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_SP = 3'd1,
        PUSH_WR = 3'd2,
        POP_RD  = 3'd3,
        POP_SP  = 3'd4,
        RESP    = 3'd5
    } state_e;

    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates push/pop requests from two requesters onto a single stack
// made of an external stack pointer block and a data memory.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_op,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_op,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp0_err,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              resp1_err,
    input  logic [DATA_W-1:0] sp,
    input  logic              sp_empty,
    input  logic              sp_full,
    output logic [1:0]        sp_ctrl,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state, next_state;
    logic [1:0]        grant;
    logic              last_q, owner_q, op_q, err_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              accept, acc_owner, acc_op, acc_err, resp_fire;
    logic [DATA_W-1:0] acc_wdata, resp_data;

    rr_arbiter2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    // Ready implies valid because the arbiter only grants valid requesters.
    assign req0_ready = (state == IDLE) && !reset && grant[0];
    assign req1_ready = (state == IDLE) && !reset && grant[1];
    assign accept     = req0_ready | req1_ready;
    assign acc_owner  = req1_ready;
    assign acc_op     = acc_owner ? req1_op : req0_op;
    assign acc_wdata  = acc_owner ? req1_wdata : req0_wdata;
    assign acc_err    = (acc_op == OP_PUSH) ? sp_full : sp_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= OP_POP;
            err_q   <= 1'b0;
        end else if (accept) begin
            last_q  <= acc_owner;
            owner_q <= acc_owner;
            op_q    <= acc_op;
            err_q   <= acc_err;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            wdata_q <= acc_wdata;
        end
        if (state == POP_SP) begin
            rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        next_state = state;
        sp_ctrl    = SP_DEF;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_err) begin
                        next_state = RESP;
                    end else if (acc_op == OP_PUSH) begin
                        next_state = PUSH_SP;
                    end else begin
                        next_state = POP_RD;
                    end
                end
            end
            PUSH_SP: begin
                sp_ctrl    = SP_PUSH;
                next_state = PUSH_WR;
            end
            PUSH_WR: begin
                mem_wr     = 1'b1;
                mem_addr   = sp;
                mem_wdata  = wdata_q;
                next_state = RESP;
            end
            POP_RD: begin
                mem_rd     = 1'b1;
                mem_addr   = sp;
                next_state = POP_SP;
            end
            POP_SP: begin
                sp_ctrl    = SP_POP;
                next_state = RESP;
            end
            RESP: begin
                resp_fire  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Only a successful pop returns data; pushes and errors return zero.
    assign resp_data   = (op_q == OP_POP && !err_q) ? rdata_q : '0;
    assign resp0_valid = resp_fire && !owner_q;
    assign resp1_valid = resp_fire && owner_q;
    assign resp0_rdata = resp0_valid ? resp_data : '0;
    assign resp1_rdata = resp1_valid ? resp_data : '0;
    assign resp0_err   = resp0_valid && err_q;
    assign resp1_err   = resp1_valid && err_q;

endmodule
